// File: rtl/mem_pkg.sv
// Shared types and defaults for the parametrised memory controller.
// The parity helper exists only when PARITY_EN is defined.
package mem_pkg;

   localparam int MEM_DATA_W_DEF = 8;
   localparam int MEM_ADDR_W_DEF = 3;
   localparam int PAR_MAX_W      = 256;

   typedef enum logic [1:0] {
      CLEAR = 2'd0,
      IDLE  = 2'd1,
      SLEEP = 2'd2
   } state_e;

`ifdef PARITY_EN
   // Callers zero-extend to PAR_MAX_W; zero padding does not change parity.
   function automatic logic even_parity(input logic [PAR_MAX_W-1:0] data);
      return ^data;
   endfunction
`endif

endpackage

// File: rtl/addr_decoder.sv
// One-hot word select for the memory array; all zeros while en is low.
module addr_decoder
   import mem_pkg::*;
#(
   parameter int ADDR_W = MEM_ADDR_W_DEF
) (
   input  logic                   en,
   input  logic [ADDR_W-1:0]      adr,
   output logic [(1<<ADDR_W)-1:0] sel
);

   always_comb begin
      sel = '0;
      if (en) begin
         sel[adr] = 1'b1;
      end
   end

endmodule

// File: rtl/param_mem_ctrl.sv
// DEPTH x DATA_W word memory with registered read, zero-clear sweep after reset,
// sleep mode and illegal-request flag. Define PARITY_EN for per-word even parity.
//
// state | meaning
// ------+--------------------------------------------------------------
// CLEAR | writes zero to word clr_cnt each cycle, then goes to IDLE
// IDLE  | ready when sleep=0; services one read or write per cycle
// SLEEP | array untouched, contents retained, requests dropped
module param_mem_ctrl
   import mem_pkg::*;
#(
   parameter int DATA_W = MEM_DATA_W_DEF,
   parameter int ADDR_W = MEM_ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              read,
   input  logic              write,
   input  logic [ADDR_W-1:0] adr,
   input  logic [DATA_W-1:0] inputs,
   input  logic              sleep,
`ifdef PARITY_EN
   input  logic              inj_par_err,
   output logic              par_err,
`endif
   output logic              ready,
   output logic [DATA_W-1:0] outputs,
   output logic              out_valid,
   output logic              err,
   output logic              err_sticky
);

   localparam int DEPTH = 1 << ADDR_W;
`ifdef PARITY_EN
   localparam int WORD_W = DATA_W + 1;
`else
   localparam int WORD_W = DATA_W;
`endif
   localparam logic [ADDR_W:0] CLR_LAST = (ADDR_W+1)'(DEPTH - 1);

   state_e            state_q, state_d;
   logic [ADDR_W:0]   clr_cnt_q, clr_cnt_d;
   logic [DATA_W-1:0] outputs_q, outputs_d;
   logic              out_valid_q, out_valid_d;
   logic              err_q, err_d;
   logic              err_sticky_q, err_sticky_d;
   logic              par_err_q, par_err_d;

   logic [WORD_W-1:0] mem_q [DEPTH];
   logic [WORD_W-1:0] wr_word;
   logic [WORD_W-1:0] rd_word;
   logic [ADDR_W-1:0] wr_adr;
   logic              wr_en;
   logic [DEPTH-1:0]  wr_sel;

   assign rd_word = mem_q[adr];
   assign ready   = (state_q == IDLE) && !sleep;

   always_comb begin
      state_d      = state_q;
      clr_cnt_d    = clr_cnt_q;
      outputs_d    = outputs_q;
      out_valid_d  = 1'b0;
      err_d        = 1'b0;
      err_sticky_d = err_sticky_q;
      par_err_d    = 1'b0;
      wr_en        = 1'b0;
      wr_adr       = adr;
`ifdef PARITY_EN
      wr_word      = {even_parity(PAR_MAX_W'(inputs)) ^ inj_par_err, inputs};
`else
      wr_word      = inputs;
`endif
      unique case (state_q)
         CLEAR: begin
            wr_en     = 1'b1;
            wr_adr    = clr_cnt_q[ADDR_W-1:0];
            wr_word   = '0;
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == CLR_LAST) begin
               state_d = IDLE;
            end
         end
         IDLE: begin
            // sleep wins over any request presented in the same cycle
            if (sleep) begin
               state_d = SLEEP;
            end else if (read && write) begin
               err_d        = 1'b1;
               err_sticky_d = 1'b1;
            end else if (write) begin
               wr_en = 1'b1;
            end else if (read) begin
               outputs_d   = rd_word[DATA_W-1:0];
               out_valid_d = 1'b1;
`ifdef PARITY_EN
               if (even_parity(PAR_MAX_W'(rd_word[DATA_W-1:0])) != rd_word[DATA_W]) begin
                  par_err_d    = 1'b1;
                  err_sticky_d = 1'b1;
               end
`endif
            end
         end
         SLEEP: begin
            if (!sleep) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = CLEAR;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= CLEAR;
         clr_cnt_q    <= '0;
         outputs_q    <= '0;
         out_valid_q  <= 1'b0;
         err_q        <= 1'b0;
         err_sticky_q <= 1'b0;
         par_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         clr_cnt_q    <= clr_cnt_d;
         outputs_q    <= outputs_d;
         out_valid_q  <= out_valid_d;
         err_q        <= err_d;
         err_sticky_q <= err_sticky_d;
         par_err_q    <= par_err_d;
      end
   end

   addr_decoder #(
      .ADDR_W (ADDR_W)
   ) u_addr_decoder (
      .en  (wr_en),
      .adr (wr_adr),
      .sel (wr_sel)
   );

   // Storage is deliberately unreset; the CLEAR sweep zeroes it.
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (wr_sel[i]) begin
            mem_q[i] <= wr_word;
         end
      end
   end

   assign outputs    = outputs_q;
   assign out_valid  = out_valid_q;
   assign err        = err_q;
   assign err_sticky = err_sticky_q;
`ifdef PARITY_EN
   assign par_err    = par_err_q;
`else
   logic unused_par;
   assign unused_par = par_err_q;
`endif

endmodule

// File: tb/tb_param_mem_ctrl.sv
// Scoreboard bench for param_mem_ctrl (DATA_W=8, ADDR_W=3); directed vectors.
module tb_param_mem_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       read = 1'b0;
   logic       write = 1'b0;
   logic       sleep = 1'b0;
   logic [2:0] adr = '0;
   logic [7:0] inputs = '0;
   logic       ready, out_valid, err, err_sticky;
   logic [7:0] outputs;
`ifdef PARITY_EN
   logic       inj_par_err = 1'b0;
   logic       par_err;
`endif

   typedef struct packed {
      logic [7:0] data;
      logic       par;
   } exp_t;

   exp_t exp_q[$];
   int   err_pending = 0;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   n_clr;

   param_mem_ctrl #(.DATA_W(8), .ADDR_W(3)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .read       (read),
      .write      (write),
      .adr        (adr),
      .inputs     (inputs),
      .sleep      (sleep),
`ifdef PARITY_EN
      .inj_par_err(inj_par_err),
      .par_err    (par_err),
`endif
      .ready      (ready),
      .outputs    (outputs),
      .out_valid  (out_valid),
      .err        (err),
      .err_sticky (err_sticky)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
      end
   endtask

   // Monitor: pops one expectation per out_valid cycle.
   always @(negedge clk) begin
      exp_t e;
      if (out_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_out_valid: got outputs 0x%0h, expected no read", outputs);
         end else begin
            e = exp_q.pop_front();
            check("read_data", 32'(outputs), 32'(e.data));
`ifdef PARITY_EN
            check("par_err", 32'(par_err), 32'(e.par));
`endif
         end
      end
`ifdef PARITY_EN
      if (par_err === 1'b1 && out_valid !== 1'b1) begin
         n_cmp++;
         n_bad++;
         $display("FAIL par_err_without_valid: got par_err=1, expected 0");
      end
`endif
      if (err === 1'b1) begin
         n_cmp++;
         if (err_pending > 0) begin
            err_pending--;
         end else begin
            n_bad++;
            $display("FAIL unexpected_err: got err=1, expected 0");
         end
      end
   end

   task automatic rd(input logic [2:0] a, input logic [7:0] e, input logic p = 1'b0);
      read  = 1'b1;
      write = 1'b0;
      adr   = a;
      exp_q.push_back('{data: e, par: p});
      @(posedge clk); #1;
   endtask

   task automatic wr(input logic [2:0] a, input logic [7:0] d, input logic inj = 1'b0);
      read   = 1'b0;
      write  = 1'b1;
      adr    = a;
      inputs = d;
`ifdef PARITY_EN
      inj_par_err = inj;
`else
      if (inj) $display("note: parity injection ignored in this build");
`endif
      @(posedge clk); #1;
`ifdef PARITY_EN
      inj_par_err = 1'b0;
`endif
   endtask

   task automatic idle();
      read  = 1'b0;
      write = 1'b0;
      @(posedge clk); #1;
   endtask

   // Counts cycles with ready low after reset release; leaves read low once ready.
   task automatic wait_clear(output int n);
      n = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (ready === 1'b1) break;
         n++;
      end
      read = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] name_bytes [6];
      name_bytes = '{8'h53, 8'h69, 8'h6E, 8'h64, 8'h72, 8'h65};

      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_ready", 32'(ready), 0);
      check("rst_outputs", 32'(outputs), 0);
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_err", 32'(err), 0);
      check("rst_err_sticky", 32'(err_sticky), 0);
      rst_n = 1'b1;
      wait_clear(n_clr);
      check("clear_cycles", 32'(n_clr), 8);

      for (int a = 0; a < 8; a++) rd(3'(a), 8'h00);
      idle();

      for (int a = 0; a < 6; a++) wr(3'(a), name_bytes[a]);
      for (int a = 0; a < 6; a++) rd(3'(a), name_bytes[a]);
      wr(3'd6, 8'h5A);
      rd(3'd6, 8'h5A);
      wr(3'd7, 8'hAA);
      rd(3'd7, 8'hAA);
      idle();
      check("ready_idle", 32'(ready), 1);

      read = 1'b1; write = 1'b1; adr = 3'd2; inputs = 8'hFF;
      err_pending++;
      @(posedge clk); #1;
      read = 1'b0; write = 1'b0;
      check("err_sticky_set", 32'(err_sticky), 1);
      check("outputs_held_on_err", 32'(outputs), 32'h AA);
      idle();
      rd(3'd2, 8'h6E);
      idle();

      sleep = 1'b1; write = 1'b1; adr = 3'd0; inputs = 8'h00;
      #1;
      check("ready_sleep_req", 32'(ready), 0);
      @(posedge clk); #1;
      write = 1'b0; read = 1'b1;
      @(posedge clk); #1;
      check("ready_in_sleep", 32'(ready), 0);
      read = 1'b0; sleep = 1'b0;
      #1;
      check("ready_wake_same_cycle", 32'(ready), 0);
      @(posedge clk); #1;
      check("ready_after_wake", 32'(ready), 1);
      rd(3'd0, 8'h53);
      rd(3'd7, 8'hAA);
      idle();

      check("err_sticky_before_rst", 32'(err_sticky), 1);
      rst_n = 1'b0;
      #1;
      check("err_sticky_after_rst", 32'(err_sticky), 0);
      check("outputs_after_rst", 32'(outputs), 0);
      check("ready_after_rst", 32'(ready), 0);
      @(posedge clk); #1;
      read = 1'b1; adr = 3'd1;
      rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("outputs_mid_clear_rst", 32'(outputs), 0);
      check("ready_mid_clear_rst", 32'(ready), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      wait_clear(n_clr);
      check("clear_cycles_restart", 32'(n_clr), 8);
      rd(3'd6, 8'h00);
      rd(3'd0, 8'h00);
      idle();

`ifdef PARITY_EN
      wr(3'd1, 8'h53, 1'b1);
      rd(3'd1, 8'h53, 1'b1);
      idle();
      check("err_sticky_par", 32'(err_sticky), 1);
      wr(3'd1, 8'h07);
      rd(3'd1, 8'h07, 1'b0);
      idle();
`endif

      repeat (3) idle();
      check("scoreboard_empty", 32'(exp_q.size()), 0);
      check("err_pending", 32'(err_pending), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
